cam_nn_rgb_packer: RTL and testbench

Packs the 2PPC RGB stream from the 2x nearest-neighbour scale-down stage into 32-bit little-endian words for the NN input DMA. It absorbs the bursty, un-throttled scaler output through a byte gearbox and word FIFO, and drives a valid/ready stream with an end-of-frame marker. It sits directly downstream of the scale-down stage and upstream of the DMA write master.

---
 rtl/cam_nn_rgb_packer.sv | 191 +++++++++++++++++++
 tb/tb_cam_nn_rgb_packer.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/cam_nn_rgb_packer.sv
// cam_nn_rgb_packer
//
// Packs the 2-pixel-per-clock RGB stream from the 2x nearest-neighbour
// scale-down stage into 32-bit little-endian words for the NN input DMA.
// Each input beat carries 6 bytes. A 16-byte accumulator (the gearbox)
// turns them into 4-byte words, and a word FIFO absorbs the bursty input.
//
// Optional feature macro: CAM_NN_PACKER_BGR_EN
//   defined   : per-beat byte order B0,G0,R0,B1,G1,R1
//   undefined : per-beat byte order R0,G0,B0,R1,G1,B1
//
// Ports
//   clk, rst_n          pixel clock, asynchronous active-low reset
//   in_frame_start      one-cycle frame start pulse (may coincide with a beat)
//   in_red/green/blue   pixel0 in [P_DEPTH-1:0], pixel1 in the upper half
//   in_valid            beat qualifier; no backpressure toward the scaler
//   out_data/out_last   packed word and end-of-frame marker
//   out_valid/out_ready output stream handshake
//   stat_overflow       sticky: a word was dropped (FIFO full) or a beat was dropped (accumulator overrun)
//   stat_sync_err       sticky: in_frame_start discarded a partial frame
//   stat_level          registered FIFO occupancy
//
// Output handshake: a word transfers on a rising edge where out_valid and
// out_ready are both high. While out_valid is high and out_ready is low,
// out_data/out_last hold. out_valid only drops after a transfer.
module cam_nn_rgb_packer #(
  parameter int P_DEPTH     = 8,     // only 8 is supported
  parameter int FRAME_BEATS = 4608,  // even, >= 2
  parameter int FIFO_DEPTH  = 16     // power of two, >= 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          in_frame_start,
  input  logic [2*P_DEPTH-1:0]          in_red,
  input  logic [2*P_DEPTH-1:0]          in_green,
  input  logic [2*P_DEPTH-1:0]          in_blue,
  input  logic                          in_valid,
  output logic [31:0]                   out_data,
  output logic                          out_last,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic                          stat_overflow,
  output logic                          stat_sync_err,
  output logic [$clog2(FIFO_DEPTH):0]   stat_level
);

  localparam int ACC_BITS = 128;
  localparam int PTR_W    = $clog2(FIFO_DEPTH);
  localparam int LVL_W    = PTR_W + 1;
  localparam int BC_W     = $clog2(FRAME_BEATS + 1);

  // Gearbox state. last_mask_q marks the byte that closes a frame, so the
  // end-of-frame flag rides along with the data through the byte shifts.
  logic [ACC_BITS-1:0] acc_q, acc_d;
  logic [15:0]         last_mask_q, mask_d;
  logic [4:0]          acc_cnt_q, cnt_d;
  logic [BC_W-1:0]     beat_cnt_q, beat_cnt_d;

  logic [ACC_BITS-1:0] rem_data;
  logic [15:0]         rem_mask;
  logic [4:0]          rem_cnt;
  logic [BC_W-1:0]     beat_base;
  logic [6*P_DEPTH-1:0] beat_bytes;

  logic        gb_push;
  logic [32:0] push_word;
  logic        beat_take;
  logic        beat_overrun;
  logic        beat_is_last;
  logic        sync_err_set;

  // FIFO state
  logic [32:0]      fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [LVL_W-1:0] level_q, level_d;
  logic             fifo_full, fifo_pop, fifo_wr, fifo_drop;

  // Beat bytes, byte0 in the least significant position.
`ifdef CAM_NN_PACKER_BGR_EN
  assign beat_bytes = {in_red[2*P_DEPTH-1:P_DEPTH], in_green[2*P_DEPTH-1:P_DEPTH],
                       in_blue[2*P_DEPTH-1:P_DEPTH], in_red[P_DEPTH-1:0],
                       in_green[P_DEPTH-1:0], in_blue[P_DEPTH-1:0]};
`else
  assign beat_bytes = {in_blue[2*P_DEPTH-1:P_DEPTH], in_green[2*P_DEPTH-1:P_DEPTH],
                       in_red[2*P_DEPTH-1:P_DEPTH], in_blue[P_DEPTH-1:0],
                       in_green[P_DEPTH-1:0], in_red[P_DEPTH-1:0]};
`endif

  assign sync_err_set = in_frame_start && ((acc_cnt_q != 5'd0) || (beat_cnt_q != '0));

  always_comb begin
    // A frame start throws away whatever the accumulator holds, including
    // any complete word that would otherwise be pushed this cycle.
    gb_push   = (acc_cnt_q >= 5'd4) && !in_frame_start;
    push_word = {|last_mask_q[3:0], acc_q[31:0]};

    if (in_frame_start) begin
      rem_data  = '0;
      rem_mask  = '0;
      rem_cnt   = '0;
      beat_base = '0;
    end else if (gb_push) begin
      rem_data  = acc_q >> 32;
      rem_mask  = last_mask_q >> 4;
      rem_cnt   = acc_cnt_q - 5'd4;
      beat_base = beat_cnt_q;
    end else begin
      rem_data  = acc_q;
      rem_mask  = last_mask_q;
      rem_cnt   = acc_cnt_q;
      beat_base = beat_cnt_q;
    end

    // 6 more bytes fit only while 10 or fewer remain after the push.
    beat_take    = in_valid && (rem_cnt <= 5'd10);
    beat_overrun = in_valid && (rem_cnt > 5'd10);
    beat_is_last = beat_take && (beat_base == BC_W'(FRAME_BEATS - 1));

    acc_d      = rem_data;
    mask_d     = rem_mask;
    cnt_d      = rem_cnt;
    beat_cnt_d = beat_base;
    if (beat_take) begin
      acc_d      = rem_data | (ACC_BITS'(beat_bytes) << {rem_cnt, 3'b000});
      cnt_d      = rem_cnt + 5'd6;
      beat_cnt_d = beat_is_last ? '0 : beat_base + BC_W'(1);
      // Byte 5 of the closing beat carries the end-of-frame mark.
      if (beat_is_last) mask_d = rem_mask | (16'h0020 << rem_cnt);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q       <= '0;
      last_mask_q <= '0;
      acc_cnt_q   <= '0;
      beat_cnt_q  <= '0;
    end else begin
      acc_q       <= acc_d;
      last_mask_q <= mask_d;
      acc_cnt_q   <= cnt_d;
      beat_cnt_q  <= beat_cnt_d;
    end
  end

  // FIFO: a push while full is accepted only if a pop frees a slot in the
  // same cycle; otherwise the word is lost but the gearbox still consumes it.
  assign fifo_full = (level_q == LVL_W'(FIFO_DEPTH));
  assign fifo_pop  = out_valid && out_ready;
  assign fifo_wr   = gb_push && (!fifo_full || fifo_pop);
  assign fifo_drop = gb_push && fifo_full && !fifo_pop;

  always_comb begin
    level_d = level_q;
    if (fifo_wr && !fifo_pop)      level_d = level_q + LVL_W'(1);
    else if (!fifo_wr && fifo_pop) level_d = level_q - LVL_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) fifo_mem[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (fifo_wr) begin
        fifo_mem[wr_ptr_q] <= push_word;
        wr_ptr_q           <= wr_ptr_q + PTR_W'(1);
      end
      if (fifo_pop) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      level_q <= level_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_overflow <= 1'b0;
      stat_sync_err <= 1'b0;
    end else begin
      stat_overflow <= stat_overflow | beat_overrun | fifo_drop;
      stat_sync_err <= stat_sync_err | sync_err_set;
    end
  end

  // Head of FIFO drives the output directly; it cannot change until popped.
  assign out_valid  = (level_q != '0);
  assign out_data   = fifo_mem[rd_ptr_q][31:0];
  assign out_last   = fifo_mem[rd_ptr_q][32];
  assign stat_level = level_q;

endmodule

// File: tb/tb_cam_nn_rgb_packer.sv
// Testbench for cam_nn_rgb_packer with FRAME_BEATS=4, FIFO_DEPTH=16.
module tb_cam_nn_rgb_packer;

  localparam int FB    = 4;
  localparam int DEPTH = 16;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        in_frame_start = 1'b0;
  logic [15:0] in_red = '0, in_green = '0, in_blue = '0;
  logic        in_valid = 1'b0;
  logic [31:0] out_data;
  logic        out_last, out_valid;
  logic        out_ready = 1'b0;
  logic        stat_overflow, stat_sync_err;
  logic [4:0]  stat_level;

  cam_nn_rgb_packer #(.P_DEPTH(8), .FRAME_BEATS(FB), .FIFO_DEPTH(DEPTH)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_frame_start(in_frame_start),
    .in_red(in_red), .in_green(in_green), .in_blue(in_blue), .in_valid(in_valid),
    .out_data(out_data), .out_last(out_last), .out_valid(out_valid), .out_ready(out_ready),
    .stat_overflow(stat_overflow), .stat_sync_err(stat_sync_err), .stat_level(stat_level)
  );

  // ---------------- scoreboard state ----------------
  int n_checks = 0;
  int n_fail   = 0;
  int popped   = 0;
  int drop_n   = 0;
  int mdl_beat = 0;
  logic [32:0] exp_q[$];
  logic [8:0]  mdl_bytes[$];
  logic        hold_pending = 1'b0;
  logic [32:0] hold_word = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
    end
  endtask

  // Reference model: byte stream in, words out (little-endian, 4 bytes each).
  function automatic void mdl_frame_start();
    mdl_bytes.delete();
    mdl_beat = 0;
  endfunction

  function automatic void mdl_beat_in(input logic [15:0] r, input logic [15:0] g, input logic [15:0] b);
    logic [7:0]  by [6];
    logic [31:0] w;
    logic        lst;
    logic [8:0]  e;
`ifdef CAM_NN_PACKER_BGR_EN
    by = '{b[7:0], g[7:0], r[7:0], b[15:8], g[15:8], r[15:8]};
`else
    by = '{r[7:0], g[7:0], b[7:0], r[15:8], g[15:8], b[15:8]};
`endif
    mdl_beat++;
    for (int i = 0; i < 6; i++) mdl_bytes.push_back({(i == 5) && (mdl_beat == FB), by[i]});
    if (mdl_beat == FB) mdl_beat = 0;
    while (mdl_bytes.size() >= 4) begin
      w = '0;
      lst = 1'b0;
      for (int j = 0; j < 4; j++) begin
        e = mdl_bytes.pop_front();
        w[8*j +: 8] = e[7:0];
        lst = lst | e[8];
      end
      if (drop_n > 0) drop_n--;
      else exp_q.push_back({lst, w});
    end
  endfunction

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (rst_n) begin
      if (hold_pending) begin
        check("hold_valid", 64'(out_valid), 64'd1);
        check("hold_word", 64'({out_last, out_data}), 64'(hold_word));
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_word: got %0h, expected no word", {out_last, out_data});
        end else begin
          check("word", 64'({out_last, out_data}), 64'(exp_q.pop_front()));
        end
        popped++;
      end
      hold_pending = out_valid && !out_ready;
      hold_word    = {out_last, out_data};
    end else begin
      hold_pending = 1'b0;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic drive(input logic fs, input logic v, input logic [15:0] r,
                       input logic [15:0] g, input logic [15:0] b);
    @(posedge clk);
    #1;
    in_frame_start = fs;
    in_valid       = v;
    in_red         = r;
    in_green       = g;
    in_blue        = b;
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, 1'b0, 16'h0, 16'h0, 16'h0);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    exp_q.delete();
    mdl_frame_start();
    drop_n = 0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // One frame: frame start, FB beats on alternate cycles, then settle.
  task automatic send_frame(input logic [15:0] base, input int drop_last, input logic chk_lat);
    logic [15:0] off;
    drive(1'b1, 1'b0, 16'h0, 16'h0, 16'h0);
    mdl_frame_start();
    for (int k = 0; k < FB; k++) begin
      off = base + 16'(k) * 16'h0404;
      if (k == FB - 1) drop_n = drop_last;
      drive(1'b0, 1'b1, 16'h1101 + off, 16'h2202 + off, 16'h3303 + off);
      mdl_beat_in(16'h1101 + off, 16'h2202 + off, 16'h3303 + off);
      if (chk_lat && k == 0) begin
        idle(1);
        @(negedge clk);
        check("lat_t1_valid", 64'(out_valid), 64'd0);
        idle(1);
        @(negedge clk);
        check("lat_t2_valid", 64'(out_valid), 64'd1);
`ifdef CAM_NN_PACKER_BGR_EN
        check("first_word", 64'(out_data), 64'h3301_0203);
`else
        check("first_word", 64'(out_data), 64'h1103_0201);
`endif
      end else begin
        idle(1);
      end
    end
    idle(4);
  endtask

  task automatic wait_drain(input string name, input int budget);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(posedge clk);
      #1;
      n++;
    end
    check(name, 64'(exp_q.size()), 64'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    #23;
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_out_data", 64'(out_data), 64'd0);
    check("rst_out_last", 64'(out_last), 64'd0);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_overflow", 64'(stat_overflow), 64'd0);
    check("rst_sync_err", 64'(stat_sync_err), 64'd0);
    check("rst_level", 64'(stat_level), 64'd0);

    // Basic frame, streaming output.
    out_ready = 1'b1;
    popped = 0;
    send_frame(16'h0000, 0, 1'b1);
    wait_drain("s1_drain", 50);
    check("s1_word_count", 64'(popped), 64'd6);

    // Backpressure: two frames held in the FIFO, then drained in order.
    out_ready = 1'b0;
    send_frame(16'h0010, 0, 1'b0);
    send_frame(16'h0020, 0, 1'b0);
    idle(2);
    check("bp_level", 64'(stat_level), 64'd12);
    check("bp_overflow", 64'(stat_overflow), 64'd0);
    check("bp_sync_err", 64'(stat_sync_err), 64'd0);
    out_ready = 1'b1;
    wait_drain("bp_drain", 100);
    idle(2);
    check("bp_level_empty", 64'(stat_level), 64'd0);

    // FIFO overflow: third frame's final two words are dropped.
    do_reset();
    out_ready = 1'b0;
    send_frame(16'h0030, 0, 1'b0);
    send_frame(16'h0040, 0, 1'b0);
    send_frame(16'h0050, 2, 1'b0);
    idle(2);
    check("ovf_level", 64'(stat_level), 64'd16);
    check("ovf_flag", 64'(stat_overflow), 64'd1);
    out_ready = 1'b1;
    wait_drain("ovf_drain", 100);
    send_frame(16'h0060, 0, 1'b0);
    wait_drain("ovf_realign", 50);
    check("ovf_no_sync_err", 64'(stat_sync_err), 64'd0);

    // Sync error: frame start after one beat discards the 2 residual bytes.
    do_reset();
    out_ready = 1'b1;
    popped = 0;
    drive(1'b1, 1'b0, 16'h0, 16'h0, 16'h0);
    mdl_frame_start();
    drive(1'b0, 1'b1, 16'h1171, 16'h2272, 16'h3373);
    mdl_beat_in(16'h1171, 16'h2272, 16'h3373);
    idle(3);
    check("sync_err_before", 64'(stat_sync_err), 64'd0);
    send_frame(16'h0080, 0, 1'b0);
    check("sync_err_set", 64'(stat_sync_err), 64'd1);
    wait_drain("sync_drain", 50);
    check("sync_word_count", 64'(popped), 64'd7);

    // Back-to-back beats: the 7th consecutive beat overruns the accumulator.
    do_reset();
    out_ready = 1'b1;
    drive(1'b1, 1'b0, 16'h0, 16'h0, 16'h0);
    mdl_frame_start();
    for (int k = 0; k < 7; k++) begin
      drive(1'b0, 1'b1, 16'h1191 + 16'(k), 16'h2292 + 16'(k), 16'h3393 + 16'(k));
      if (k < 6) mdl_beat_in(16'h1191 + 16'(k), 16'h2292 + 16'(k), 16'h3393 + 16'(k));
      else check("b2b_overflow_before", 64'(stat_overflow), 64'd0);
    end
    idle(1);
    check("b2b_overflow_after", 64'(stat_overflow), 64'd1);
    idle(4);
    wait_drain("b2b_drain", 50);
    idle(2);
    check("final_level", 64'(stat_level), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // ---------------- watchdog ----------------
  initial begin
    #200000;
    n_checks++;
    n_fail++;
    $display("FAIL timeout: simulation did not complete, expected completion before %0t", $time);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
